// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing block: ALU opcodes and round-robin pointer states.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_LUI = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110
   } alu_op_e;

   typedef enum logic {
      LAST_P0 = 1'b0,
      LAST_P1 = 1'b1
   } rr_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; opcode 111 is undefined and yields result 0, Zero 0.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [2:0]            op_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  zero_o
);

   always_comb begin
      result_o = '0;
      zero_o   = 1'b0;
      case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: begin
            result_o = a_i - b_i;
            zero_o   = (a_i == b_i);
         end
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_LUI: result_o = b_i;
         ALU_SLT: begin
            result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            zero_o   = (a_i == b_i);
         end
         ALU_SLL: result_o = a_i << b_i[4:0];
         default: begin
            result_o = '0;
            zero_o   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted port and holds when idle.
module rr_arb2
   import alu_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] elig_i,
   output logic [1:0] grant_o
);

   rr_state_e state_q, state_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= LAST_P1;
      else       state_q <= state_d;
   end

   always_comb begin
      grant_o = 2'b00;
      state_d = state_q;
      if (elig_i == 2'b11) begin
         grant_o = (state_q == LAST_P0) ? 2'b10 : 2'b01;
      end else begin
         grant_o = elig_i;
      end
      if (grant_o[0])      state_d = LAST_P0;
      else if (grant_o[1]) state_d = LAST_P1;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant and a
// registered result slot per port.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0][DATA_WIDTH-1:0] req_srca_i,
   input  logic [1:0][DATA_WIDTH-1:0] req_srcb_i,
   input  logic [1:0][2:0]            req_op_i,
   output logic [1:0]                 rsp_valid_o,
   input  logic [1:0]                 rsp_ready_i,
   output logic [1:0][DATA_WIDTH-1:0] rsp_result_o,
   output logic [1:0]                 rsp_zero_o
);

   logic [1:0]                 elig;
   logic [1:0]                 grant;
   logic                       sel;
   logic [DATA_WIDTH-1:0]      alu_a, alu_b, alu_res;
   logic [2:0]                 alu_op;
   logic                       alu_zero;

   logic [1:0]                 rsp_valid_q, rsp_valid_d;
   logic [1:0][DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [1:0]                 rsp_zero_q, rsp_zero_d;

   // A full slot may accept a new request in the same cycle it is being drained.
   assign elig = req_valid_i & (~rsp_valid_q | rsp_ready_i);

   rr_arb2 u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .elig_i  (elig),
      .grant_o (grant)
   );

   assign sel    = grant[1];
   assign alu_a  = req_srca_i[sel];
   assign alu_b  = req_srcb_i[sel];
   assign alu_op = req_op_i[sel];

   alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .op_i     (alu_op),
      .result_o (alu_res),
      .zero_o   (alu_zero)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      for (int unsigned p = 0; p < 2; p++) begin
         if (rsp_valid_q[p] && rsp_ready_i[p]) rsp_valid_d[p] = 1'b0;
         if (grant[p]) begin
            rsp_valid_d[p]  = 1'b1;
            rsp_result_d[p] = alu_res;
            rsp_zero_d[p]   = alu_zero;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign req_ready_o  = grant;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_zero_o   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: hand-computed vectors checked with immediate assertions.
module tb_alu_share_arbiter;

   localparam int unsigned DW = 32;

   logic                clk;
   logic                rst;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0][DW-1:0]  srca;
   logic [1:0][DW-1:0]  srcb;
   logic [1:0][2:0]     op;
   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready;
   logic [1:0][DW-1:0]  rsp_result;
   logic [1:0]          rsp_zero;

   int vectors;
   int miscompares;

   alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_srca_i   (srca),
      .req_srcb_i   (srcb),
      .req_op_i     (op),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_result_o (rsp_result),
      .rsp_zero_o   (rsp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op[p]   = o;
      srca[p] = a;
      srcb[p] = b;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      req_valid   = 2'b11;
      rsp_ready   = 2'b11;
      set_req(0, 3'b000, 32'd5, 32'd7);
      set_req(1, 3'b000, 32'd1, 32'd2);

      // 1: reset, then first grant goes to port 0
      tick();
      tick();
      chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("reset_result0", rsp_result[0], 32'd0);
      chk("reset_zero", {30'd0, rsp_zero}, 32'd0);
      rst = 1'b0;
      #1;
      chk("first_grant", {30'd0, req_ready}, 32'd1);

      // 2: p0 ADD 5,7 -> 12
      tick();
      chk("add_result0", rsp_result[0], 32'd12);
      chk("add_zero0", {31'd0, rsp_zero[0]}, 32'd0);
      chk("add_valid", {30'd0, rsp_valid}, 32'd1);
      req_valid = 2'b10;
      #1;
      chk("p1_only_grant", {30'd0, req_ready}, 32'd2);
      tick();
      chk("p1_add_result", rsp_result[1], 32'd3);
      chk("p1_add_valid", {30'd0, rsp_valid}, 32'd2);

      // 3: both valid, alternating grants starting at port 0
      req_valid = 2'b11;
      set_req(0, 3'b001, 32'd9, 32'd9);
      set_req(1, 3'b101, 32'hFFFF_FFFD, 32'd2);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_grant", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         if (i % 2 == 0) begin
            chk("sub_eq_result0", rsp_result[0], 32'd0);
            chk("sub_eq_zero0", {31'd0, rsp_zero[0]}, 32'd1);
         end else begin
            chk("slt_neg_result1", rsp_result[1], 32'd1);
            chk("slt_neg_zero1", {31'd0, rsp_zero[1]}, 32'd0);
         end
      end

      // 4: p0 slot full and not draining blocks p0 only
      rsp_ready = 2'b10;
      req_valid = 2'b01;
      set_req(0, 3'b000, 32'd1, 32'd1);
      #1;
      chk("p0_grant_empty", {30'd0, req_ready}, 32'd1);
      tick();
      chk("hold_fill_result0", rsp_result[0], 32'd2);
      req_valid = 2'b11;
      set_req(0, 3'b001, 32'd4, 32'd1);
      set_req(1, 3'b000, 32'd10, 32'd20);
      #1;
      chk("blocked_p0_grant_p1", {30'd0, req_ready}, 32'd2);
      tick();
      chk("held_result0", rsp_result[0], 32'd2);
      chk("held_valid0", {31'd0, rsp_valid[0]}, 32'd1);
      chk("unblocked_p1_result", rsp_result[1], 32'd30);
      req_valid = 2'b01;
      rsp_ready = 2'b11;
      #1;
      chk("drain_refill_grant", {30'd0, req_ready}, 32'd1);
      tick();
      chk("refill_result0", rsp_result[0], 32'd3);
      chk("refill_valid0", {31'd0, rsp_valid[0]}, 32'd1);

      // 5: reset with results held discards them and resets the pointer
      rsp_ready = 2'b00;
      req_valid = 2'b10;
      set_req(1, 3'b000, 32'd2, 32'd2);
      #1;
      chk("p1_grant_before_rst", {30'd0, req_ready}, 32'd2);
      tick();
      chk("both_held_valid", {30'd0, rsp_valid}, 32'd3);
      chk("p1_held_result", rsp_result[1], 32'd4);
      rsp_ready = 2'b01;
      req_valid = 2'b01;
      set_req(0, 3'b000, 32'd3, 32'd3);
      #1;
      chk("p0_drain_grant", {30'd0, req_ready}, 32'd1);
      tick();
      chk("p0_result6", rsp_result[0], 32'd6);
      rst = 1'b1;
      req_valid = 2'b00;
      tick();
      chk("midrst_valid", {30'd0, rsp_valid}, 32'd0);
      chk("midrst_result1", rsp_result[1], 32'd0);
      rst = 1'b0;
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      set_req(0, 3'b110, 32'd1, 32'd33);
      set_req(1, 3'b000, 32'd0, 32'd0);
      #1;
      chk("post_rst_grant_p0", {30'd0, req_ready}, 32'd1);

      // 6: ALU corner cases on port 0
      tick();
      chk("sll_result", rsp_result[0], 32'd2);
      req_valid = 2'b01;
      set_req(0, 3'b111, 32'd5, 32'd5);
      tick();
      chk("undef_result", rsp_result[0], 32'd0);
      chk("undef_zero", {31'd0, rsp_zero[0]}, 32'd0);
      set_req(0, 3'b100, 32'd5, 32'h1234_5000);
      tick();
      chk("lui_result", rsp_result[0], 32'h1234_5000);
      set_req(0, 3'b000, 32'hFFFF_FFFF, 32'd1);
      tick();
      chk("add_wrap_result", rsp_result[0], 32'd0);
      chk("add_wrap_zero", {31'd0, rsp_zero[0]}, 32'd0);
      set_req(0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00);
      tick();
      chk("and_result", rsp_result[0], 32'h0000_F000);
      set_req(0, 3'b011, 32'h0000_F0F0, 32'h0000_FF00);
      tick();
      chk("or_result", rsp_result[0], 32'h0000_FFF0);
      set_req(0, 3'b001, 32'd0, 32'd1);
      tick();
      chk("sub_neg_result", rsp_result[0], 32'hFFFF_FFFF);
      chk("sub_neg_zero", {31'd0, rsp_zero[0]}, 32'd0);
      set_req(0, 3'b101, 32'd7, 32'd7);
      tick();
      chk("slt_eq_result", rsp_result[0], 32'd0);
      chk("slt_eq_zero", {31'd0, rsp_zero[0]}, 32'd1);
      set_req(0, 3'b101, 32'd2, 32'hFFFF_FFFD);
      tick();
      chk("slt_pos_neg_result", rsp_result[0], 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
